alu_bist_ctrl: RTL and testbench
================================

Name: alu_bist_ctrl

Overview:
- Hardware built-in self-test controller for the 74181-compatible `alu` slice: the stimulus/response end of the same port set the verification agent drives.
- Generates an exhaustive sweep of {s, m, cn, a, b} on registered outputs and captures every ALU response {f, p, g, a_eq_b, cn_4}.
- Compacts the responses into a 16-bit MISR signature and compares it against a golden value.
- Sits beside the `alu` instance and is wired port-for-port to it.

Parameters:
- VEC_BITS, 14, number of low counter bits swept (1..14); run length = 2^VEC_BITS vectors.
- SETTLE_CYCLES, 1, idle cycles between driving a vector and capturing its response (0..15).
- GOLDEN_SIG, 16'h0000, expected final MISR signature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle or done.
- s  out  4  ALU function select.
- a  out  4  ALU operand A.
- b  out  4  ALU operand B.
- cn  out  1  ALU carry-in.
- m  out  1  ALU mode (1 = logic).
- f  in  4  ALU result.
- p  in  1  ALU propagate.
- g  in  1  ALU generate.
- a_eq_b  in  1  ALU equality flag.
- cn_4  in  1  ALU carry-out.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next start.
- pass  out  1  valid when done; 1 means signature == GOLDEN_SIG.
- signature  out  16  current MISR value.

Behaviour:
- Reset is asynchronous, active-low, and forces these values:
  - s, a, b, cn, m = 0
  - busy, done, pass = 0
  - signature = 16'hFFFF
  - state = IDLE
  - vector counter = 0
- Reset asserted mid-run aborts immediately to these values.
- Vector counter vc is 14 bits; bits at and above VEC_BITS stay 0. Mapping: vc[3:0]=b, vc[7:4]=a, vc[8]=cn, vc[9]=m, vc[13:10]=s.
- States: IDLE, DRIVE, WAIT, CAPTURE, DONE.
- IDLE or DONE, start=1 -> DRIVE:
  - clear vc, done, pass;
  - set signature = 16'hFFFF and busy = 1.
- DRIVE (1 cycle): registers s/a/b/cn/m from vc. Next state is WAIT if SETTLE_CYCLES > 0, else CAPTURE.
- WAIT: runs for exactly SETTLE_CYCLES cycles, then -> CAPTURE.
- CAPTURE (1 cycle):
  - resp = {cn_4, a_eq_b, g, p, f[3:0]};
  - signature <= ({sig[14:0],1'b0} ^ (sig[15] ? 16'h100B : 0)) ^ {8'h00, resp};
  - if vc == 2^VEC_BITS-1 -> DONE; else vc+1, -> DRIVE.
- Cost per vector: SETTLE_CYCLES+2 cycles. With defaults, 49152 cycles from the start-sample edge to DONE entry.
- DONE:
  - busy = 0, done = 1;
  - pass is registered as (signature == GOLDEN_SIG), evaluated on the final MISR value;
  - ALU stimulus outputs hold the last vector.
- start while busy is ignored; there is no restart mid-run.
- start in DONE begins a new run the next cycle.
- Inputs are treated as stable during CAPTURE. No synchronisation is required (same clock domain, combinational ALU).
- Counter wrap: vc never wraps during a run; the terminal compare happens before increment.

Test Plan:
- Reset values: assert rst_n=0 mid-run -> next sample busy=0, done=0, pass=0, signature=16'hFFFF, s/a/b/cn/m=0; start after release begins a clean run.
- Zero response: VEC_BITS=1, SETTLE_CYCLES=0, tie resp inputs to 0, pulse start -> done after 4 cycles, signature=16'hCFE1; GOLDEN_SIG=16'hCFE1 gives pass=1.
- All-ones response: VEC_BITS=1, resp inputs tied to 8'hFF -> signature=16'hCEE0, pass=0 with GOLDEN_SIG=16'hCFE1.
- Stimulus order: defaults, monitor DRIVE outputs -> b increments first, then a, cn, m, s; first vector all-zero, last s=F, m=1, cn=1, a=F, b=F; busy high for exactly 49152 cycles.
- Real ALU plus fault:
  - Run with the `alu` connected and GOLDEN_SIG set to the captured signature -> pass=1.
  - Rerun with f[0] forced 0 -> pass=0.
- start pulses while busy -> ignored, cycle count unchanged; start in DONE -> new run, done drops next cycle.

Source files
------------

// File: rtl/alu_bist_ctrl.sv
// -----------------------------------------------------------------------------
// alu_bist_ctrl -- built-in self-test controller for a 74181-style ALU slice.
// Sweeps {s, m, cn, a, b} exhaustively over 2^VEC_BITS vectors, compacts every
// ALU response into a 16-bit MISR and compares the final value to GOLDEN_SIG.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   start               one-cycle pulse, begins a run from IDLE or DONE
//   s, a, b, cn, m      registered ALU stimulus
//   f, p, g, a_eq_b,    ALU response, captured during CAPTURE
//   cn_4
//   busy                high while a run is in progress
//   done                high from run completion until the next start
//   pass                valid with done; final signature == GOLDEN_SIG
//   signature           current MISR value
// -----------------------------------------------------------------------------
module alu_bist_ctrl #(
   parameter int unsigned VEC_BITS      = 14,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter logic [15:0] GOLDEN_SIG    = 16'h0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic [3:0]  s,
   output logic [3:0]  a,
   output logic [3:0]  b,
   output logic        cn,
   output logic        m,
   input  logic [3:0]  f,
   input  logic        p,
   input  logic        g,
   input  logic        a_eq_b,
   input  logic        cn_4,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [15:0] signature
);

   localparam int unsigned VC_W   = 14;
   localparam int unsigned SIG_W  = 16;
   localparam int unsigned RESP_W = 8;
   localparam int unsigned WAIT_W = 4;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_DRIVE   = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_CAPTURE = 3'd3;
   localparam logic [2:0] ST_DONE    = 3'd4;

   localparam logic [VC_W-1:0]   VC_LAST   = VC_W'((32'd1 << VEC_BITS) - 32'd1);
   localparam logic [WAIT_W-1:0] WAIT_LOAD =
      (SETTLE_CYCLES == 0) ? WAIT_W'(0) : WAIT_W'(SETTLE_CYCLES - 1);
   localparam logic [SIG_W-1:0]  MISR_POLY = 16'h100B;
   localparam logic [SIG_W-1:0]  SIG_SEED  = 16'hFFFF;

   logic [2:0]        state_q, state_d;
   logic [VC_W-1:0]   vc_q, vc_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [3:0]        s_q, s_d, a_q, a_d, b_q, b_d;
   logic              cn_q, cn_d, m_q, m_d;
   logic              busy_q, busy_d, done_q, done_d, pass_q, pass_d;
   logic [SIG_W-1:0]  sig_q, sig_d;

   logic [RESP_W-1:0] resp_c;
   logic [SIG_W-1:0]  misr_next_c;

   // Response byte and next MISR value (shift, feedback on MSB, fold response)
   always_comb begin
      resp_c      = {cn_4, a_eq_b, g, p, f};
      misr_next_c = ({sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0))
                    ^ {8'h00, resp_c};
   end

   // Next-state and next-output logic
   always_comb begin
      state_d = state_q;
      vc_d    = vc_q;
      wait_d  = wait_q;
      s_d     = s_q;
      a_d     = a_q;
      b_d     = b_q;
      cn_d    = cn_q;
      m_d     = m_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      sig_d   = sig_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               state_d = ST_DRIVE;
               vc_d    = '0;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               sig_d   = SIG_SEED;
               busy_d  = 1'b1;
            end
         end
         ST_DRIVE: begin
            s_d  = vc_q[13:10];
            m_d  = vc_q[9];
            cn_d = vc_q[8];
            a_d  = vc_q[7:4];
            b_d  = vc_q[3:0];
            if (SETTLE_CYCLES == 0) begin
               state_d = ST_CAPTURE;
            end else begin
               wait_d  = WAIT_LOAD;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            // Counter holds the remaining settle cycles minus one
            if (wait_q == '0) begin
               state_d = ST_CAPTURE;
            end else begin
               wait_d = wait_q - WAIT_W'(1);
            end
         end
         ST_CAPTURE: begin
            sig_d = misr_next_c;
            // Terminal compare precedes increment so vc never wraps
            if (vc_q == VC_LAST) begin
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               pass_d  = (misr_next_c == GOLDEN_SIG);
            end else begin
               vc_d    = vc_q + VC_W'(1);
               state_d = ST_DRIVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         vc_q    <= '0;
         wait_q  <= '0;
         s_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
         cn_q    <= 1'b0;
         m_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         sig_q   <= SIG_SEED;
      end else begin
         state_q <= state_d;
         vc_q    <= vc_d;
         wait_q  <= wait_d;
         s_q     <= s_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cn_q    <= cn_d;
         m_q     <= m_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         sig_q   <= sig_d;
      end
   end

   assign s         = s_q;
   assign a         = a_q;
   assign b         = b_q;
   assign cn        = cn_q;
   assign m         = m_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign signature = sig_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_bist_ctrl -- self-checking bench for alu_bist_ctrl.
// Three instances: a 2-vector zero-settle build with fixed responses, the
// default full sweep, and a 256-vector build with a 3-cycle settle. The ALU is
// stood in for by a random response table indexed by the stimulus word; the
// expected signature is recomputed from that table in sweep order.
// -----------------------------------------------------------------------------
module tb_alu_bist_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic start0, start1, start2;
   logic fault;

   logic [7:0] lut [16384];

   // Instance 0: VEC_BITS=1, SETTLE_CYCLES=0, response driven directly
   logic [3:0]  s0, a0, b0;
   logic        cn0, m0, busy0, done0, pass0;
   logic [15:0] sig0;
   logic [7:0]  resp0;

   // Instance 1: defaults
   logic [3:0]  s1, a1, b1;
   logic        cn1, m1, busy1, done1, pass1;
   logic [15:0] sig1;
   logic [7:0]  resp1;
   logic [13:0] idx1;

   // Instance 2: VEC_BITS=8, SETTLE_CYCLES=3
   logic [3:0]  s2, a2, b2;
   logic        cn2, m2, busy2, done2, pass2;
   logic [15:0] sig2;
   logic [7:0]  resp2;
   logic [13:0] idx2;

   localparam logic [15:0] GOLD2 = 16'h5A5A;

   assign idx1  = {s1, m1, cn1, a1, b1};
   assign resp1 = lut[idx1];
   assign idx2  = {s2, m2, cn2, a2, b2};
   assign resp2 = lut[idx2] & {7'h7F, ~fault};

   alu_bist_ctrl #(.VEC_BITS(1), .SETTLE_CYCLES(0), .GOLDEN_SIG(16'hCFE1)) u0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .s(s0), .a(a0), .b(b0), .cn(cn0), .m(m0),
      .f(resp0[3:0]), .p(resp0[4]), .g(resp0[5]), .a_eq_b(resp0[6]), .cn_4(resp0[7]),
      .busy(busy0), .done(done0), .pass(pass0), .signature(sig0));

   alu_bist_ctrl u1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .s(s1), .a(a1), .b(b1), .cn(cn1), .m(m1),
      .f(resp1[3:0]), .p(resp1[4]), .g(resp1[5]), .a_eq_b(resp1[6]), .cn_4(resp1[7]),
      .busy(busy1), .done(done1), .pass(pass1), .signature(sig1));

   alu_bist_ctrl #(.VEC_BITS(8), .SETTLE_CYCLES(3), .GOLDEN_SIG(GOLD2)) u2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .s(s2), .a(a2), .b(b2), .cn(cn2), .m(m2),
      .f(resp2[3:0]), .p(resp2[4]), .g(resp2[5]), .a_eq_b(resp2[6]), .cn_4(resp2[7]),
      .busy(busy2), .done(done2), .pass(pass2), .signature(sig2));

   int n_pass   = 0;
   int n_checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   // Signature of the first n vectors: the MISR is polynomial division, i.e.
   // multiply by x modulo x^16+x^12+x^3+x+1, then add the response byte.
   function automatic logic [15:0] misr_model(input int n, input bit drop_f0);
      logic [16:0] acc;
      logic [7:0]  r;
      acc = 17'h0FFFF;
      for (int k = 0; k < n; k++) begin
         r = lut[k];
         if (drop_f0) r[0] = 1'b0;
         acc = acc * 17'd2;
         if (acc >= 17'h10000) acc = acc ^ 17'h1100B;
         acc = acc ^ {9'h000, r};
      end
      return acc[15:0];
   endfunction

   task automatic pulse(input int sel);
      case (sel)
         0: start0 = 1'b1;
         1: start1 = 1'b1;
         default: start2 = 1'b1;
      endcase
      @(posedge clk); #1;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   initial begin
      int          n;
      int          bad;
      logic [15:0] exp_sig;

      for (int k = 0; k < 16384; k++) lut[k] = 8'($urandom);
      rst_n  = 1'b0;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      fault  = 1'b0;
      resp0  = 8'h00;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      check("rst_sig0", 32'(sig0), 32'h0000FFFF);
      check("rst_flags1", 32'({busy1, done1, pass1}), 32'h0);
      check("rst_stim1", 32'(idx1), 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Zero response, 2 vectors, no settle
      pulse(0);
      n = 0;
      while (!done0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("u0_zero_latency", 32'(n), 32'd4);
      check("u0_zero_sig", 32'(sig0), 32'h0000CFE1);
      check("u0_zero_pass", 32'(pass0), 32'd1);
      check("u0_zero_busy", 32'(busy0), 32'd0);
      check("u0_last_vec", 32'({s0, m0, cn0, a0, b0}), 32'h1);

      // All-ones response, started from DONE
      resp0 = 8'hFF;
      pulse(0);
      check("u0_done_drop", 32'({done0, busy0, pass0}), 32'b010);
      check("u0_restart_sig", 32'(sig0), 32'h0000FFFF);
      n = 0;
      while (!done0 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("u0_ones_latency", 32'(n), 32'd4);
      check("u0_ones_sig", 32'(sig0), 32'h0000CEE0);
      check("u0_ones_pass", 32'(pass0), 32'd0);

      // Reset asserted mid-run aborts to reset values
      pulse(2);
      repeat (50) @(posedge clk);
      #1;
      check("u2_busy_before_rst", 32'(busy2), 32'd1);
      rst_n = 1'b0;
      #1;
      check("u2_rst_stim", 32'(idx2), 32'h0);
      check("u2_rst_flags", 32'({busy2, done2, pass2}), 32'h0);
      check("u2_rst_sig", 32'(sig2), 32'h0000FFFF);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Clean run with start pulses ignored while busy
      pulse(2);
      n   = 0;
      bad = 0;
      while (!done2 && n < 5000) begin
         start2 = (n == 10 || n == 600) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         start2 = 1'b0;
         n++;
         if (!done2 && !busy2) bad++;
      end
      exp_sig = misr_model(256, 1'b0);
      check("u2_cycles", 32'(n), 32'd1280);
      check("u2_busy_gap", 32'(bad), 32'd0);
      check("u2_sig", 32'(sig2), 32'(exp_sig));
      check("u2_pass", 32'(pass2), 32'(exp_sig == GOLD2));

      // Same run with f[0] stuck at 0
      fault = 1'b1;
      pulse(2);
      n = 0;
      while (!done2 && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      exp_sig = misr_model(256, 1'b1);
      check("u2_fault_cycles", 32'(n), 32'd1280);
      check("u2_fault_sig", 32'(sig2), 32'(exp_sig));
      check("u2_fault_pass", 32'(pass2), 32'(exp_sig == GOLD2));
      fault = 1'b0;

      // Full default sweep: vector k is presented from cycle 3k+1 on
      pulse(1);
      n   = 0;
      bad = 0;
      while (!done1 && n < 50000) begin
         @(posedge clk); #1;
         n++;
         if (idx1 !== 14'((n - 1) / 3)) bad++;
         if (!done1 && !busy1) bad++;
         if (n == 1) check("u1_first_vec", 32'(idx1), 32'h0);
         if (n == 4) check("u1_second_vec_b", 32'({s1, m1, cn1, a1, b1}), 32'h1);
         if (n == 7) check("u1_third_vec_b", 32'(b1), 32'h2);
      end
      exp_sig = misr_model(16384, 1'b0);
      check("u1_stim_order", 32'(bad), 32'd0);
      check("u1_busy_cycles", 32'(n), 32'd49152);
      check("u1_last_vec", 32'({s1, m1, cn1, a1, b1}), 32'h3FFF);
      check("u1_sig", 32'(sig1), 32'(exp_sig));
      check("u1_pass", 32'(pass1), 32'(exp_sig == 16'h0000));
      check("u1_idle_flags", 32'({busy1, done1}), 32'b01);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
